dmem_responder: RTL and testbench

Data-memory responder at the far end of the execute stage's data-memory request port. It accepts at most one load or store per cycle and applies stores to an internal byte-laned word RAM. Load data is returned registered, lane-aligned and sign/zero-extended, on the same clock edge that latches the issuing instruction into the execute output register. The memory/writeback stage can then consume `rdata_ro` alongside `result_ro` with no extra stall.

---
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-laned word RAM with registered, lane-aligned, sign/zero-extended load data.
// Optional build macro DMEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of aligning them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_width_i,
    input  logic        req_unsigned_i,
    output logic [31:0] rdata_ro,
    output logic        rvalid_ro,
    output logic        err_ro,
    output logic        wr_busy_o
);

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

    width_e      width;
    logic [AW-1:0] word_idx;
    logic [1:0]  lane_off;
    logic        reject;
    logic [3:0]  byte_en;
    logic [31:0] lane_wdata;
    logic        store_en;
    logic [31:0] rd_word;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;
    logic        unused_addr_bits;

    logic [7:0] lane_mem [4][DEPTH_WORDS];

    assign width    = width_e'(req_width_i);
    assign word_idx = req_addr_i[AW+1:2];

    // Upper address bits alias by design.
    assign unused_addr_bits = ^req_addr_i[31:AW+2];

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_off   = req_addr_i[1:0];
        reject     = 1'b0;
        byte_en    = 4'b0000;
        lane_wdata = req_wdata_i;
        case (width)
            WIDTH_BYTE: begin
                byte_en    = 4'b0001 << req_addr_i[1:0];
                lane_wdata = {4{req_wdata_i[7:0]}};
            end
            WIDTH_HALF: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                reject   = req_addr_i[0];
`else
                lane_off = {req_addr_i[1], 1'b0};
`endif
                byte_en    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata_i[15:0]}};
            end
            WIDTH_WORD: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                reject   = |req_addr_i[1:0];
`else
                lane_off = 2'b00;
`endif
                byte_en = 4'b1111;
            end
            default: reject = 1'b1;
        endcase
    end

    assign store_en  = req_valid_i & req_write_i & ~reject;
    assign wr_busy_o = req_valid_i & req_write_i;

    // NOTE: the RAM has no reset, so contents survive rst and the arrays map onto plain memory.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (store_en && byte_en[lane]) begin
                lane_mem[lane][word_idx] <= lane_wdata[8*lane +: 8];
            end
        end
    end

    // Read sees the array state before the edge; only one request exists per cycle.
    assign rd_word    = {lane_mem[3][word_idx], lane_mem[2][word_idx],
                         lane_mem[1][word_idx], lane_mem[0][word_idx]};
    assign rd_shifted = rd_word >> {lane_off, 3'b000};

    always_comb begin
        load_data = rd_word;
        case (width)
            WIDTH_BYTE: load_data = req_unsigned_i ? {24'h0, rd_shifted[7:0]}
                                                   : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            WIDTH_HALF: load_data = req_unsigned_i ? {16'h0, rd_shifted[15:0]}
                                                   : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default:    load_data = rd_word;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_ro  <= '0;
            rvalid_ro <= 1'b0;
            err_ro    <= 1'b0;
        end else begin
            rvalid_ro <= 1'b0;
            err_ro    <= 1'b0;
            if (req_valid_i) begin
                if (reject) begin
                    rdata_ro <= '0;
                    err_ro   <= 1'b1;
                end else if (!req_write_i) begin
                    rdata_ro  <= load_data;
                    rvalid_ro <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses, a negedge monitor pops and compares.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [1:0] W_B = 2'b00;
    localparam logic [1:0] W_H = 2'b01;
    localparam logic [1:0] W_W = 2'b10;
    localparam logic [1:0] W_R = 2'b11;

    typedef struct packed {
        logic [31:0] data;
        logic        v;
        logic        e;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_width_i;
    logic        req_unsigned_i;
    logic [31:0] rdata_ro;
    logic        rvalid_ro;
    logic        err_ro;
    logic        wr_busy_o;

    resp_t exp_q[$];
    resp_t mon_exp;
    int    n_checks = 0;
    int    n_pass   = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .AW(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_write_i    (req_write_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_width_i    (req_width_i),
        .req_unsigned_i (req_unsigned_i),
        .rdata_ro       (rdata_ro),
        .rvalid_ro      (rvalid_ro),
        .err_ro         (err_ro),
        .wr_busy_o      (wr_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One request cycle; called at posedge+1, returns at the following posedge+1.
    task automatic req(input logic wr, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic uns,
                       input logic exp_v, input logic exp_e, input logic [31:0] exp_d);
        req_valid_i    = 1'b1;
        req_write_i    = wr;
        req_width_i    = w;
        req_addr_i     = a;
        req_wdata_i    = d;
        req_unsigned_i = uns;
        if (exp_v || exp_e) exp_q.push_back('{data: exp_d, v: exp_v, e: exp_e});
        #1;
        check("wr_busy", {31'h0, wr_busy_o}, {31'h0, wr});
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic idle_check(input logic [31:0] hold);
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rdata", rdata_ro, hold);
        check("idle_rvalid", {31'h0, rvalid_ro}, 32'h0);
        check("idle_err", {31'h0, err_ro}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (rvalid_ro || err_ro) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got rdata=%h rvalid=%b err=%b expected no response",
                         rdata_ro, rvalid_ro, err_ro);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp_rdata", rdata_ro, mon_exp.data);
                check("resp_rvalid", {31'h0, rvalid_ro}, {31'h0, mon_exp.v});
                check("resp_err", {31'h0, err_ro}, {31'h0, mon_exp.e});
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i = '0;
        req_wdata_i = '0;
        req_width_i = W_W;
        req_unsigned_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", rdata_ro, 32'h0);
        check("reset_rvalid", {31'h0, rvalid_ro}, 32'h0);
        check("reset_err", {31'h0, err_ro}, 32'h0);
        check("reset_wr_busy", {31'h0, wr_busy_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word store, then signed/unsigned byte loads back to back
        req(1, W_W, 32'h100, 32'h80FF7F01, 0, 0, 0, 0);
        req(0, W_B, 32'h100, 0, 0, 1, 0, 32'h00000001);
        req(0, W_B, 32'h101, 0, 0, 1, 0, 32'h0000007F);
        req(0, W_B, 32'h102, 0, 0, 1, 0, 32'hFFFFFFFF);
        req(0, W_B, 32'h103, 0, 0, 1, 0, 32'hFFFFFF80);
        req(0, W_B, 32'h103, 0, 1, 1, 0, 32'h00000080);

        // Half store merges into upper lanes
        req(1, W_W, 32'h20, 32'h11223344, 0, 0, 0, 0);
        req(1, W_H, 32'h22, 32'h0000BEEF, 0, 0, 0, 0);
        req(0, W_W, 32'h20, 0, 0, 1, 0, 32'hBEEF3344);
        req(0, W_H, 32'h22, 0, 0, 1, 0, 32'hFFFFBEEF);
        req(0, W_H, 32'h20, 0, 1, 1, 0, 32'h00003344);

        // Store then immediate load, then hold over idle cycles
        req(1, W_W, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0);
        req(0, W_W, 32'h40, 0, 0, 1, 0, 32'hDEADBEEF);
        repeat (3) idle_check(32'hDEADBEEF);

        // Aliasing modulo 4*DEPTH_WORDS
        req(1, W_W, 32'h4, 32'h12345600, 0, 0, 0, 0);
        req(1, W_B, 32'h1004, 32'hFFFFFF5A, 0, 0, 0, 0);
        req(0, W_W, 32'h4, 0, 0, 1, 0, 32'h1234565A);
        req(0, W_B, 32'h1005, 0, 1, 1, 0, 32'h00000056);

        // Misaligned accesses: rejected with trap, aligned down without
        req(1, W_W, 32'h41, 32'hCAFEF00D, 0, 0, TRAP, 0);
        req(0, W_W, 32'h40, 0, 0, 1, 0, TRAP ? 32'hDEADBEEF : 32'hCAFEF00D);
        req(0, W_H, 32'h23, 0, 0, !TRAP, TRAP, TRAP ? 32'h0 : 32'hFFFFBEEF);

        // Reserved width is rejected for store and load
        req(1, W_R, 32'h40, 32'h0BADF00D, 0, 0, 1, 32'h0);
        req(0, W_W, 32'h40, 0, 0, 1, 0, TRAP ? 32'hDEADBEEF : 32'hCAFEF00D);
        req(0, W_R, 32'h100, 0, 0, 0, 1, 32'h0);
        idle_check(32'h0);

        // Reset with a load pending: outputs clear at once, RAM survives
        req(0, W_W, 32'h20, 0, 0, 1, 0, 32'hBEEF3344);
        @(negedge clk);
        #1;
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_width_i = W_W;
        req_addr_i  = 32'h40;
        rst = 1'b1;
        #1;
        check("rst_async_rdata", rdata_ro, 32'h0);
        check("rst_async_rvalid", {31'h0, rvalid_ro}, 32'h0);
        check("rst_async_err", {31'h0, err_ro}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_rvalid", {31'h0, rvalid_ro}, 32'h0);
        req_valid_i = 1'b0;
        rst = 1'b0;
        req(0, W_W, 32'h100, 0, 0, 1, 0, 32'h80FF7F01);
        req(0, W_B, 32'h1103, 0, 1, 1, 0, 32'h00000080);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
